wb_stream_fetch: RTL
====================

WB_STREAM_FETCH -- requirements
Module: wb_stream_fetch

Interface
REQ-001 SHALL have parameter WB_DW, default 32, Wishbone and stream data width in bits.
REQ-002 SHALL have parameter WB_AW, default 32, Wishbone byte address width.
REQ-003 SHALL have parameter FIFO_AW, default 4, FIFO depth 2**FIFO_AW words.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 2**FIFO_AW, burst length cap in words.
REQ-005 SHALL have port clk, input, 1, sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port wbm_adr_o, output, WB_AW, byte address of the current beat.
REQ-008 SHALL have port wbm_sel_o, output, WB_DW/8, constant all ones.
REQ-009 SHALL have port wbm_we_o, output, 1, constant 0 (read only).
REQ-010 SHALL have ports wbm_cyc_o and wbm_stb_o, output, 1 each, cycle and strobe.
REQ-011 SHALL have ports wbm_cti_o, output, 3, and wbm_bte_o, output, 2, burst type tags.
REQ-012 SHALL have port wbm_dat_i, input, WB_DW, read data.
REQ-013 SHALL have ports wbm_ack_i and wbm_err_i, input, 1 each, beat acknowledge and error.
REQ-014 SHALL have ports stream_m_data_o, output, WB_DW, and stream_m_valid_o, output, 1, stream output.
REQ-015 SHALL have port stream_m_ready_i, input, 1, stream consumer ready.
REQ-016 SHALL have port enable, input, 1, run control.
REQ-017 SHALL have ports start_adr, buf_size and burst_size, input, WB_AW each: buffer base (byte address), buffer length (words), burst length (words).
REQ-018 SHALL have port irq_o, output, 1, buffer-complete interrupt.

Function
REQ-019 SHALL read a circular buffer of buf_size words from start_adr and present the words in address order on the stream port.
REQ-020 SHALL buffer read data in an internal FIFO of 2**FIFO_AW words; a stream transfer occurs when stream_m_valid_o and stream_m_ready_i are both 1.
REQ-021 SHALL use FSM states IDLE and BURST; IDLE->BURST when enable=1 and FIFO free space >= the next burst length; BURST->IDLE on the last acknowledged beat or on wbm_err_i.
REQ-022 SHALL set the burst length to min(burst_size, MAX_BURST_LEN, words remaining before buffer end), with burst_size 0 treated as 1.
REQ-023 SHALL hold wbm_cyc_o=wbm_stb_o=1 throughout BURST and 0 in IDLE, with wbm_bte_o=00.
REQ-024 SHALL drive wbm_cti_o=010 on non-final beats, 111 on the final beat, and 111 when the burst length is 1.
REQ-025 SHALL advance wbm_adr_o by WB_DW/8 on each wbm_ack_i and push wbm_dat_i into the FIFO in the same cycle.
REQ-026 SHALL, after word buf_size-1, wrap the next address to start_adr and pulse the completion event for one cycle.
REQ-027 SHALL, on wbm_err_i, discard that beat, end the cycle, and keep the address pointing at the errored word so the next burst retries it.
REQ-028 SHALL let a burst in progress complete when enable falls, and SHALL start no new burst until enable is 1 again.
REQ-029 SHALL sample start_adr, buf_size and burst_size only in IDLE; changes during BURST take effect at the next burst.
REQ-030 SHALL, on a rising edge of enable, reload the address to start_adr and the word count to 0.
REQ-031 SHALL NOT overflow the FIFO: a simultaneous push and pop leaves the occupancy unchanged, and stream_m_valid_o=0 when the FIFO is empty.

Reset
REQ-032 SHALL, while rst=1, clear the FSM to IDLE, empty the FIFO, set the address to 0 and the word count to 0, and drive wbm_cyc_o, wbm_stb_o, stream_m_valid_o and irq_o to 0 and wbm_cti_o to 000, taking effect immediately and aborting any burst in progress.

Configuration
REQ-033 SHALL, with WB_STREAM_FETCH_IRQ_EN defined, set irq_o sticky on the completion event and clear it on a rising edge of enable or on rst.
REQ-034 SHALL, without WB_STREAM_FETCH_IRQ_EN, tie irq_o to 0 and leave the port present.

Verification
REQ-035 SHALL verify: start_adr=0x100, buf_size=8, burst_size=4, consumer always ready -> two 4-beat bursts at 0x100 and 0x110, cti 010,010,010,111, stream carries the 8 words in order, then the address wraps to 0x100.
REQ-036 SHALL verify: buf_size=6, burst_size=4 -> bursts of 4 and then 2 words, last beat at 0x114, cti 111 on beats 4 and 6.
REQ-037 SHALL verify: FIFO_AW=2, burst_size=4, stream_m_ready_i=0 -> one burst fills the FIFO, no new cyc until 4 words are popped, no data lost.
REQ-038 SHALL verify: wbm_err_i on beat 2 of a burst from 0x200 -> cyc drops the next cycle, 1 word pushed, the next burst starts at 0x204.
REQ-039 SHALL verify: rst asserted mid-burst -> wbm_cyc_o and stream_m_valid_o go to 0 without a clock edge, and the FIFO is empty after release.
REQ-040 SHALL verify: with WB_STREAM_FETCH_IRQ_EN, buf_size=4 -> irq_o rises after the 4th ack and clears when enable toggles 0->1; without the macro irq_o stays 0.

Source files
------------

// File: rtl/wb_stream_fetch.sv
// wb_stream_fetch
//   Reads a circular buffer of buf_size words starting at byte address
//   start_adr over a Wishbone (registered-feedback burst) read master and
//   streams the words, in address order, out of a small internal FIFO.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   wbm_*                 Wishbone read master (sel all ones, we tied 0, bte 00)
//   stream_m_data_o/valid_o/ready_i   stream source, transfer on valid&ready
//   enable                run control; a rising edge restarts at start_adr
//   start_adr             buffer base (bytes)
//   buf_size, burst_size  buffer length and preferred burst length (words)
//   irq_o                 buffer-complete interrupt
//
// Configuration
//   WB_STREAM_FETCH_IRQ_EN  when defined, irq_o is a sticky flag set each time
//                           the last buffer word is fetched and cleared by a
//                           rising edge of enable; otherwise irq_o is 0.
module wb_stream_fetch #(
  parameter int WB_DW         = 32,
  parameter int WB_AW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic               clk,
  input  logic               rst,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  output logic [WB_DW-1:0]   stream_m_data_o,
  output logic               stream_m_valid_o,
  input  logic               stream_m_ready_i,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               irq_o
);

  localparam int               DEPTH      = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_W    = (FIFO_AW+1)'(DEPTH);
  localparam logic [WB_AW-1:0] BEAT_BYTES = WB_AW'(WB_DW/8);
  localparam logic [WB_AW-1:0] MAX_LEN    = WB_AW'(MAX_BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;
  state_t state_reg, state_next;

  logic [WB_AW-1:0]   adr_reg, cnt_reg, start_reg, size_reg, beats_left_reg;
  logic               enable_d_reg, restart_reg;
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   fill_reg;
  logic [WB_DW-1:0]   fifo_mem [0:DEPTH-1];

  logic [WB_AW-1:0] burst_req, remain, len_cap, burst_len, fifo_free;
  logic             enable_rise, start_ok, beat_ok, last_beat, last_word;
  logic             push, pop;

  // Burst length for the next burst, evaluated from the live inputs while
  // idle: min(burst_size (0 -> 1), MAX_BURST_LEN, words left before wrap).
  always_comb begin
    burst_req = (burst_size == '0) ? WB_AW'(1) : burst_size;
    remain    = (cnt_reg < buf_size) ? (buf_size - cnt_reg) : WB_AW'(1);
    len_cap   = (burst_req < MAX_LEN) ? burst_req : MAX_LEN;
    burst_len = (len_cap < remain) ? len_cap : remain;
    fifo_free = WB_AW'(DEPTH_W - fill_reg);
  end

  assign enable_rise = enable & ~enable_d_reg;
  // A pending restart must reload the pointer before the next burst starts.
  assign start_ok    = enable & ~enable_rise & ~restart_reg & (fifo_free >= burst_len);
  assign beat_ok     = (state_reg == BURST) & wbm_ack_i & ~wbm_err_i;
  assign last_beat   = (beats_left_reg == WB_AW'(1));
  // ">=" rather than "==" so a shrunken or zero buf_size still wraps.
  assign last_word   = ((cnt_reg + WB_AW'(1)) >= size_reg);
  assign push        = beat_ok;
  assign pop         = stream_m_valid_o & stream_m_ready_i;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = BURST;
      BURST:   if (wbm_err_i || (wbm_ack_i && last_beat)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wbm_cyc_o = (state_reg == BURST);
    wbm_stb_o = (state_reg == BURST);
    wbm_cti_o = 3'b000;
    if (state_reg == BURST) wbm_cti_o = last_beat ? 3'b111 : 3'b010;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WB_DW/8; gi++) begin : g_sel
      assign wbm_sel_o[gi] = 1'b1;
    end
  endgenerate

  assign wbm_we_o  = 1'b0;
  assign wbm_bte_o = 2'b00;
  assign wbm_adr_o = adr_reg;

  // Address / word pointer and the configuration snapshot used for wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_reg        <= '0;
      cnt_reg        <= '0;
      start_reg      <= '0;
      size_reg       <= '0;
      beats_left_reg <= '0;
      enable_d_reg   <= 1'b0;
      restart_reg    <= 1'b0;
    end else begin
      enable_d_reg <= enable;
      if (state_reg == IDLE) begin
        start_reg <= start_adr;
        size_reg  <= buf_size;
        if (restart_reg) begin
          adr_reg     <= start_adr;
          cnt_reg     <= '0;
          restart_reg <= 1'b0;
        end
        if (start_ok) beats_left_reg <= burst_len;
      end else if (beat_ok) begin
        beats_left_reg <= beats_left_reg - WB_AW'(1);
        if (last_word) begin
          adr_reg <= start_reg;
          cnt_reg <= '0;
        end else begin
          adr_reg <= adr_reg + BEAT_BYTES;
          cnt_reg <= cnt_reg + WB_AW'(1);
        end
      end
      // An errored beat leaves adr/cnt untouched so the retry refetches it.
      if (enable_rise) restart_reg <= 1'b1;
    end
  end

  // FIFO: a burst only starts with room for all of its beats, so push never
  // meets a full FIFO.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= wbm_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  assign stream_m_valid_o = (fill_reg != '0);
  assign stream_m_data_o  = fifo_mem[rd_ptr_reg];

`ifdef WB_STREAM_FETCH_IRQ_EN
  logic complete;
  logic irq_reg;
  assign complete = beat_ok & last_word;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              irq_reg <= 1'b0;
    else if (enable_rise) irq_reg <= 1'b0;
    else if (complete)    irq_reg <= 1'b1;
  end
  assign irq_o = irq_reg;
`else
  assign irq_o = 1'b0;
`endif

endmodule
